// File: rtl/rv32_fetch_pkg.sv
// rtl/rv32_fetch_pkg.sv - shared widths, defaults and buffer entry type for the RV32 fetch unit
package rv32_fetch_pkg;

   localparam int unsigned INSTR_W          = 32;
   localparam int unsigned XLEN_DEFAULT     = 32;
   localparam int unsigned ILEN_BYTES       = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [INSTR_W-1:0]      instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry synchronous FIFO of fetch entries; flush beats push and pop
module fetch_fifo
   import rv32_fetch_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = fetch_entry_t
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  entry_t                   push_data_i,
   input  logic                     pop_i,
   output entry_t                   head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   typedef logic [AW:0] cnt_t;

   entry_t        mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   cnt_t          count_q;
   logic          do_push;
   logic          do_pop;

   assign do_push = push_i && !flush_i;
   assign do_pop  = pop_i && !flush_i && (count_q != '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + cnt_t'(do_push) - cnt_t'(do_pop);
      end
   end

   // Storage carries no reset; the read side is qualified by empty_o.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == cnt_t'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - RV32 fetch unit with in-order prefetch buffer and redirect flush
// Optional stall counter port built when FETCH_PERF_EN is defined.
module fetch_prefetch
   import rv32_fetch_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 redirect_i,
   input  logic [XLEN-1:0]      redirect_pc_i,
   output logic                 imem_req_o,
   output logic [XLEN-1:0]      imem_addr_o,
   input  logic                 imem_gnt_i,
   input  logic                 imem_rvalid_i,
   input  logic [INSTR_W-1:0]   imem_rdata_i,
   output logic                 instr_valid_o,
   output logic [INSTR_W-1:0]   instr_o,
   output logic [XLEN-1:0]      instr_pc_o,
   input  logic                 instr_ready_i
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]          fetch_stall_cnt_o
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   typedef logic [CW-1:0] cnt_t;
   typedef logic [CW:0]   sum_t;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] rsp_pc_q;
   cnt_t            outstanding_q;
   cnt_t            discard_q;

   cnt_t            fifo_count;
   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_push;
   logic            fifo_pop;
   entry_t          fifo_head;
   entry_t          push_entry;

   logic            rsp_seen;
   logic            issue_ok;
   logic            accept;
   logic [XLEN-1:0] redirect_base;

   // A response with nothing outstanding is a stray and is ignored outright.
   assign rsp_seen      = imem_rvalid_i && (outstanding_q != '0);
   assign issue_ok      = (sum_t'(fifo_count) + sum_t'(outstanding_q)) < sum_t'(DEPTH);
   assign imem_req_o    = !redirect_i && issue_ok;
   assign imem_addr_o   = pc_q;
   assign accept        = imem_req_o && imem_gnt_i;
   assign redirect_base = redirect_pc_i & ~XLEN'(3);

   assign fifo_push       = rsp_seen && (discard_q == '0) && !redirect_i;
   assign instr_valid_o   = !fifo_empty && !redirect_i;
   assign fifo_pop        = instr_valid_o && instr_ready_i;
   assign push_entry.pc    = rsp_pc_q;
   assign push_entry.instr = imem_rdata_i;

   assign instr_o    = fifo_empty ? '0 : fifo_head.instr;
   assign instr_pc_o = fifo_empty ? RESET_PC : fifo_head.pc;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q          <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else if (redirect_i) begin
         pc_q          <= redirect_base;
         rsp_pc_q      <= redirect_base;
         outstanding_q <= outstanding_q - cnt_t'(rsp_seen);
         discard_q     <= outstanding_q - cnt_t'(rsp_seen);
      end else begin
         if (accept) pc_q <= pc_q + XLEN'(ILEN_BYTES);
         outstanding_q <= outstanding_q + cnt_t'(accept) - cnt_t'(rsp_seen);
         if (rsp_seen) begin
            if (discard_q != '0) discard_q <= discard_q - 1'b1;
            else                 rsp_pc_q  <= rsp_pc_q + XLEN'(ILEN_BYTES);
         end
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (redirect_i),
      .push_i      (fifo_push),
      .push_data_i (push_entry),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   // The credit rule on imem_req_o must make this unreachable.
   assert property (@(posedge clk_i) disable iff (rst_i) !(fifo_push && fifo_full));

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_stall_cnt_o <= '0;
      end else if (instr_ready_i && !instr_valid_o && !redirect_i &&
                   (fetch_stall_cnt_o != 32'hFFFF_FFFF)) begin
         fetch_stall_cnt_o <= fetch_stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule
